spdif_frame_encoder: RTL and testbench

Parametrised IEC 60958 consumer S/PDIF frame encoder running on the x128 fs clock. It accepts stereo PCM pairs through a valid/ready handshake and emits the biphase-mark line signal. It generates preambles, parity, validity, and a full 192-frame channel-status block with configurable sample width, copy permission and category. It sits between serial-audio capture logic and the `spdif` output pin, and adds underrun handling and block framing.

---
 rtl/spdif_pkg.sv | 28 ++
 rtl/spdif_frame_encoder_if.sv | 26 ++
 rtl/spdif_channel_status.sv | 31 +++
 rtl/spdif_frame_encoder.sv | 165 ++++++++++++++++
 tb/tb_spdif_frame_encoder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF frame encoder.
// Contents:
//   PRE_B / PRE_M / PRE_W  - preamble half-cell patterns, first half-cell in bit 7
//   SLOT_*                 - slot indices inside a 32-slot subframe
//   word_length_code()     - channel-status word-length field {b35,b34,b33,b32}
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam logic [4:0] SLOT_AUX = 5'd4;
    localparam logic [4:0] SLOT_V   = 5'd28;
    localparam logic [4:0] SLOT_C   = 5'd30;
    localparam logic [4:0] SLOT_P   = 5'd31;

    localparam int AUDIO_BITS       = 24;
    localparam int FRAMES_PER_BLOCK = 192;

    function automatic logic [3:0] word_length_code(input int width);
        case (width)
            24:      word_length_code = 4'b1011;
            20:      word_length_code = 4'b1010;
            default: word_length_code = 4'b0010;
        endcase
    endfunction

endpackage

// File: rtl/spdif_frame_encoder_if.sv
// PCM sample handshake between the serial-audio capture side and the encoder.
// Signals:
//   sample_left / sample_right - two's complement PCM pair
//   sample_valid               - pair offered by the producer
//   sample_ready               - encoder holding register is empty
//   validity_in                - V bit that travels with the pair
// Modports: master (producer), slave (encoder).
interface spdif_frame_encoder_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic [SAMPLE_WIDTH-1:0] sample_left;
    logic [SAMPLE_WIDTH-1:0] sample_right;
    logic                    sample_valid;
    logic                    sample_ready;
    logic                    validity_in;

    modport master (
        output sample_left, sample_right, sample_valid, validity_in,
        input  sample_ready
    );

    modport slave (
        input  sample_left, sample_right, sample_valid, validity_in,
        output sample_ready
    );
endinterface

// File: rtl/spdif_channel_status.sv
// Channel-status bit lookup for one 192-frame block (consumer, PCM).
// Ports:
//   fc          - frame index within the block (0..191)
//   copy_permit - latched copy permission, bit 2
//   category    - latched category code, bits 8..15
//   c_bit       - channel-status bit for frame fc
module spdif_channel_status
    import spdif_pkg::*;
#(
    parameter int         SAMPLE_WIDTH = 24,
    parameter logic [3:0] FS_CODE      = 4'b0000
) (
    input  logic [7:0] fc,
    input  logic       copy_permit,
    input  logic [7:0] category,
    output logic       c_bit
);

    logic [FRAMES_PER_BLOCK-1:0] cs_map;

    always_comb begin
        cs_map        = '0;
        cs_map[2]     = copy_permit;
        cs_map[15:8]  = category;
        cs_map[27:24] = FS_CODE;
        cs_map[35:32] = word_length_code(SAMPLE_WIDTH);
    end

    assign c_bit = (fc < 8'(FRAMES_PER_BLOCK)) ? cs_map[fc] : 1'b0;

endmodule

// File: rtl/spdif_frame_encoder.sv
// IEC 60958 consumer frame encoder, one clk128 period per BMC half-cell.
// Ports:
//   clk128, nreset  - x128 fs clock, synchronous active-low reset
//   pcm             - sample handshake (slave side)
//   copy_permit     - channel-status copy permission, latched at block start
//   category        - channel-status category, latched at block start
//   spdif           - registered biphase-mark line output
//   frame_start     - pulse on half-cell 0 of every frame
//   block_start     - pulse on half-cell 0 of frame 0
//   underrun        - pulse on half-cell 0 when the frame carries no sample pair
module spdif_frame_encoder
    import spdif_pkg::*;
#(
    parameter int         SAMPLE_WIDTH = 24,
    parameter logic [3:0] FS_CODE      = 4'b0000
) (
    input  logic                  clk128,
    input  logic                  nreset,
    spdif_frame_encoder_if.slave  pcm,
    input  logic                  copy_permit,
    input  logic [7:0]            category,
    output logic                  spdif,
    output logic                  frame_start,
    output logic                  block_start,
    output logic                  underrun
);

    // run is low in the reset state and for the start-up edge after it; that
    // edge holds hc at 0 so the first running cycle is half-cell 0 of frame 0.
    logic                    run;
    logic [6:0]              hc;
    logic [7:0]              fc;
    logic                    full;
    logic [SAMPLE_WIDTH-1:0] hold_left;
    logic [SAMPLE_WIDTH-1:0] hold_right;
    logic                    hold_v;
    logic [AUDIO_BITS-1:0]   frm_left;
    logic [AUDIO_BITS-1:0]   frm_right;
    logic                    frm_v;
    logic                    frm_under;
    logic                    cs_copy;
    logic [7:0]              cs_cat;
    logic                    pre_ref;
    logic                    c_bit;

    logic                    accept;
    logic                    transfer;
    logic [6:0]              hc_next;
    logic [7:0]              fc_next;
    logic [4:0]              slot;
    logic [AUDIO_BITS-1:0]   audio;
    logic [7:0]              pre_pat;
    logic                    pre_base;
    logic                    data_bit;
    logic                    line_next;

    assign pcm.sample_ready = run & ~full;
    assign accept           = pcm.sample_valid & pcm.sample_ready;
    assign transfer         = run & (hc == 7'd127);

    assign hc_next = run ? hc + 7'd1 : 7'd0;
    assign fc_next = !run               ? 8'd0 :
                     (hc != 7'd127)     ? fc   :
                     (fc == 8'd191)     ? 8'd0 : fc + 8'd1;

    spdif_channel_status #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .FS_CODE      (FS_CODE)
    ) u_cs (
        .fc          (fc),
        .copy_permit (cs_copy),
        .category    (cs_cat),
        .c_bit       (c_bit)
    );

    // The line is computed one cycle ahead for half-cell hc_next so that spdif
    // comes straight from a flop and lines up with hc.
    assign slot  = hc_next[5:1];
    assign audio = hc_next[6] ? frm_right : frm_left;

    always_comb begin
        pre_pat   = hc_next[6] ? PRE_W : ((fc_next == 8'd0) ? PRE_B : PRE_M);
        // Preamble polarity follows the level just before its first half-cell.
        pre_base  = (hc_next[2:0] == 3'd0) ? spdif : pre_ref;
        data_bit  = 1'b0;
        if (slot == SLOT_P)
            data_bit = ^audio ^ frm_v ^ c_bit;
        else if (slot == SLOT_C)
            data_bit = c_bit;
        else if (slot == SLOT_V)
            data_bit = frm_v;
        else if (slot >= SLOT_AUX && slot < SLOT_V)
            data_bit = audio[slot - SLOT_AUX];

        if (slot < SLOT_AUX)
            line_next = pre_pat[3'd7 - hc_next[2:0]] ^ pre_base;
        else if (!hc_next[0])
            line_next = ~spdif;
        else
            line_next = spdif ^ data_bit;
    end

    always_ff @(posedge clk128) begin
        if (!nreset) begin
            run        <= 1'b0;
            hc         <= 7'd0;
            fc         <= 8'd0;
            spdif      <= 1'b0;
            pre_ref    <= 1'b0;
            full       <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
            hold_v     <= 1'b0;
            frm_left   <= '0;
            frm_right  <= '0;
            frm_v      <= 1'b1;
            frm_under  <= 1'b1;
            cs_copy    <= copy_permit;
            cs_cat     <= category;
        end else begin
            run   <= 1'b1;
            hc    <= hc_next;
            fc    <= fc_next;
            spdif <= line_next;

            if (hc_next[5:0] == 6'd0)
                pre_ref <= spdif;

            if (accept) begin
                full       <= 1'b1;
                hold_left  <= pcm.sample_left;
                hold_right <= pcm.sample_right;
                hold_v     <= pcm.validity_in;
            end else if (transfer) begin
                full <= 1'b0;
            end

            // A pair accepted on this same cycle is not yet in the holding
            // register, so the coming frame still underruns.
            if (transfer) begin
                if (full) begin
                    frm_left  <= AUDIO_BITS'(hold_left) << (AUDIO_BITS - SAMPLE_WIDTH);
                    frm_right <= AUDIO_BITS'(hold_right) << (AUDIO_BITS - SAMPLE_WIDTH);
                    frm_v     <= hold_v;
                    frm_under <= 1'b0;
                end else begin
                    frm_left  <= '0;
                    frm_right <= '0;
                    frm_v     <= 1'b1;
                    frm_under <= 1'b1;
                end
            end

            if (!run || (transfer && fc == 8'd191)) begin
                cs_copy <= copy_permit;
                cs_cat  <= category;
            end
        end
    end

    assign frame_start = run & (hc == 7'd0);
    assign block_start = frame_start & (fc == 8'd0);
    assign underrun    = frame_start & frm_under;

endmodule

// File: tb/tb_spdif_frame_encoder.sv
// Directed bench for spdif_frame_encoder: a 24-bit instance and a 16-bit
// instance (FS_CODE 4'b0010) share clock and reset. Whole frames of the line
// are captured on the falling edge and decoded by the bench.
module tb_spdif_frame_encoder;

    bit   clk;
    logic nreset;
    logic copy_permit;
    logic [7:0] category;
    logic spdif24, fs24, bs24, ur24, rdy24;
    logic spdif16, fs16, bs16, ur16, rdy16;

    spdif_frame_encoder_if #(.SAMPLE_WIDTH(24)) pcm24 ();
    spdif_frame_encoder_if #(.SAMPLE_WIDTH(16)) pcm16 ();

    spdif_frame_encoder #(.SAMPLE_WIDTH(24), .FS_CODE(4'b0000)) dut24 (
        .clk128(clk), .nreset(nreset), .pcm(pcm24),
        .copy_permit(copy_permit), .category(category),
        .spdif(spdif24), .frame_start(fs24), .block_start(bs24), .underrun(ur24)
    );

    spdif_frame_encoder #(.SAMPLE_WIDTH(16), .FS_CODE(4'b0010)) dut16 (
        .clk128(clk), .nreset(nreset), .pcm(pcm16),
        .copy_permit(copy_permit), .category(category),
        .spdif(spdif16), .frame_start(fs16), .block_start(bs16), .underrun(ur16)
    );

    assign rdy24 = pcm24.sample_ready;
    assign rdy16 = pcm16.sample_ready;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] cap [2];
    logic         last_lvl [2];
    logic         ur_h, bs_h, rdy_h, ur16_h, bs16_h;
    int           ur_cnt, ur16_cnt, rdy_cnt, fidx, fs_cyc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // Capture the next full frame of both lines, starting at frame_start.
    task automatic capture_frame();
        int n;
        n = 0;
        last_lvl[0] = spdif24;
        last_lvl[1] = spdif16;
        @(negedge clk);
        while (!fs24 && n < 300) begin
            last_lvl[0] = spdif24;
            last_lvl[1] = spdif16;
            @(negedge clk);
            n++;
        end
        if (!fs24) begin
            check_val("frame_start_timeout", 64'(fs24), 1);
            finish_now();
        end
        fs_cyc = cyc;
        ur_h = ur24; bs_h = bs24; rdy_h = rdy24; ur16_h = ur16; bs16_h = bs16;
        ur_cnt = 0; ur16_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            if (i > 0) @(negedge clk);
            cap[0][i] = spdif24;
            cap[1][i] = spdif16;
            ur_cnt   += int'(ur24);
            ur16_cnt += int'(ur16);
            rdy_cnt  += int'(rdy24);
        end
        if (bs_h) fidx = 0;
        else      fidx++;
    endtask

    function automatic logic [7:0] pre_of(input int d, input int sf);
        logic [7:0] r;
        logic       base;
        base = (sf == 0) ? last_lvl[d] : cap[d][63];
        for (int i = 0; i < 8; i++) r[7-i] = cap[d][sf*64+i] ^ base;
        return r;
    endfunction

    function automatic logic slot_bit(input int d, input int sf, input int s);
        return cap[d][sf*64+2*s] ^ cap[d][sf*64+2*s+1];
    endfunction

    function automatic logic [23:0] audio_of(input int d, input int sf);
        logic [23:0] a;
        for (int k = 0; k < 24; k++) a[k] = slot_bit(d, sf, 4 + k);
        return a;
    endfunction

    function automatic logic parity_of(input int d, input int sf);
        logic p;
        p = 1'b0;
        for (int s = 4; s < 32; s++) p ^= slot_bit(d, sf, s);
        return p;
    endfunction

    function automatic int run3_of(input int d, input int sf);
        int n;
        n = 0;
        for (int i = sf*64 + 8; i <= sf*64 + 61; i++)
            if (cap[d][i] == cap[d][i+1] && cap[d][i+1] == cap[d][i+2]) n++;
        return n;
    endfunction

    initial begin
        logic [191:0] cb24, cb16, exp24, exp16;
        logic [7:0]   exp_pre;
        int n, blk_cyc, n_pre_bad, n_bs_bad, n_cmis, n_ur, n_par;

        nreset = 0; copy_permit = 1; category = 8'h82; fidx = 0;
        pcm24.sample_valid = 0; pcm24.sample_left = '0; pcm24.sample_right = '0;
        pcm24.validity_in = 0;
        pcm16.sample_valid = 1; pcm16.sample_left = 16'hA5A5; pcm16.sample_right = 16'h1234;
        pcm16.validity_in = 0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check_val("reset_outputs",
                {spdif24, rdy24, fs24, bs24, ur24, spdif16, rdy16, fs16, bs16, ur16}, 0);
        end
        nreset = 1;

        // Frame 0 after release: underrun frame with a B preamble
        capture_frame();
        check_val("f0_preamble_a", pre_of(0, 0), 8'b11101000);
        check_val("f0_preamble_b", pre_of(0, 1), 8'b11100100);
        check_val("f0_bs_ur_rdy", {bs_h, ur_h, rdy_h}, 3'b111);
        check_val("f0_underrun_cnt", ur_cnt, 1);
        check_val("f0_audio", {audio_of(0, 0), audio_of(0, 1)}, 0);
        check_val("f0_vbits", {slot_bit(0, 0, 28), slot_bit(0, 1, 28)}, 2'b11);

        // Continuous pairs from frame 1 on
        repeat (5) @(negedge clk);
        pcm24.sample_left = 24'h800001; pcm24.sample_right = 24'h7FFFFE;
        pcm24.validity_in = 0; pcm24.sample_valid = 1;
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            check_val("cont_underrun", ur_cnt, 0);
            check_val("cont_left", audio_of(0, 0), 24'h800001);
            check_val("cont_right", audio_of(0, 1), 24'h7FFFFE);
            check_val("cont_parity", {parity_of(0, 0), parity_of(0, 1)}, 0);
            check_val("cont_run3", run3_of(0, 0) + run3_of(0, 1), 0);
            check_val("cont_v_u", {slot_bit(0, 0, 28), slot_bit(0, 0, 29),
                                   slot_bit(0, 1, 28), slot_bit(0, 1, 29)}, 0);
            check_val("cont_preamble_m", pre_of(0, 0), 8'b11100010);
        end

        // 16-bit instance
        capture_frame();
        check_val("w16_underrun", ur16_cnt, 0);
        check_val("w16_left", audio_of(1, 0), 24'hA5A500);
        check_val("w16_right", audio_of(1, 1), 24'h123400);
        check_val("w16_parity", {parity_of(1, 0), parity_of(1, 1)}, 0);

        // Full 192-frame block
        n = 0;
        capture_frame();
        while (!bs_h && n < 200) begin
            capture_frame();
            n++;
        end
        if (!bs_h) begin
            check_val("block_start_timeout", 64'(bs_h), 1);
            finish_now();
        end
        blk_cyc = fs_cyc;
        n_pre_bad = 0; n_bs_bad = 0; n_cmis = 0; n_ur = 0; n_par = 0;
        for (int f = 0; f < 192; f++) begin
            if (f > 0) capture_frame();
            if (bs_h != (f == 0) || bs16_h != (f == 0)) n_bs_bad++;
            exp_pre = (f == 0) ? 8'b11101000 : 8'b11100010;
            if (pre_of(0, 0) != exp_pre || pre_of(0, 1) != 8'b11100100) n_pre_bad++;
            if (pre_of(1, 0) != exp_pre) n_pre_bad++;
            cb24[f] = slot_bit(0, 0, 30);
            cb16[f] = slot_bit(1, 0, 30);
            if (slot_bit(0, 1, 30) != cb24[f] || slot_bit(1, 1, 30) != cb16[f]) n_cmis++;
            n_ur += ur_cnt + ur16_cnt;
            if (parity_of(0, 0) || parity_of(0, 1) || parity_of(1, 0) || parity_of(1, 1)) n_par++;
        end
        exp24 = '0;
        exp24[2] = 1; exp24[9] = 1; exp24[15] = 1;
        exp24[32] = 1; exp24[33] = 1; exp24[35] = 1;
        exp16 = '0;
        exp16[2] = 1; exp16[9] = 1; exp16[15] = 1;
        exp16[25] = 1; exp16[33] = 1;
        check_val("cs24_lo", cb24[63:0], exp24[63:0]);
        check_val("cs24_mid", cb24[127:64], exp24[127:64]);
        check_val("cs24_hi", cb24[191:128], exp24[191:128]);
        check_val("cs16_lo", cb16[63:0], exp16[63:0]);
        check_val("cs16_rest", {cb16[191:128] != 0, cb16[127:64] != 0}, 0);
        check_val("cs16_wordlen", {cb16[35], cb16[34], cb16[33], cb16[32]}, 4'b0010);
        check_val("blk_preambles", n_pre_bad, 0);
        check_val("blk_block_start", n_bs_bad, 0);
        check_val("blk_c_ab_equal", n_cmis, 0);
        check_val("blk_underruns", n_ur, 0);
        check_val("blk_parity", n_par, 0);
        capture_frame();
        check_val("blk_next_start", {bs_h, bs16_h}, 2'b11);
        check_val("blk_period", fs_cyc - blk_cyc, 24576);

        // Handshake completing on hc = 127 into an empty register
        pcm24.sample_valid = 0;
        capture_frame();
        check_val("hs_f1_underrun", ur_cnt, 0);
        check_val("hs_f1_ready", rdy_cnt, 128);
        pcm24.sample_left = 24'h123456; pcm24.sample_right = 24'hABCDEF;
        pcm24.validity_in = 1; pcm24.sample_valid = 1;
        capture_frame();
        check_val("hs_f2_underrun", {ur_h, 8'(ur_cnt)}, {1'b1, 8'd1});
        check_val("hs_f2_audio", {audio_of(0, 0), audio_of(0, 1)}, 0);
        check_val("hs_f2_ready_low", rdy_cnt, 0);
        pcm24.sample_valid = 0;
        capture_frame();
        check_val("hs_f3_underrun", ur_cnt, 0);
        check_val("hs_f3_left", audio_of(0, 0), 24'h123456);
        check_val("hs_f3_right", audio_of(0, 1), 24'hABCDEF);
        check_val("hs_f3_vbits", {slot_bit(0, 0, 28), slot_bit(0, 1, 28)}, 2'b11);
        check_val("hs_f3_ready", {rdy_h, 8'(rdy_cnt)}, {1'b1, 8'd128});

        // Reset at hc = 70 of frame 50 with a pair held
        n = 0;
        while (fidx != 49 && n < 100) begin
            capture_frame();
            n++;
        end
        check_val("reach_frame49", fidx, 49);
        pcm24.sample_left = 24'h0F0F0F; pcm24.sample_right = 24'h0F0F0F;
        pcm24.validity_in = 0; pcm24.sample_valid = 1;
        @(negedge clk);
        pcm24.sample_valid = 0;
        repeat (70) @(negedge clk);
        check_val("held_before_reset", {rdy24, fs24}, 0);
        nreset = 0;
        repeat (4) begin
            @(negedge clk);
            check_val("mid_reset_outputs",
                {spdif24, rdy24, fs24, bs24, ur24, spdif16, rdy16, fs16, bs16, ur16}, 0);
        end
        nreset = 1;
        capture_frame();
        check_val("rst_f0_preamble", pre_of(0, 0), 8'b11101000);
        check_val("rst_f0_bs_ur_rdy", {bs_h, ur_h, rdy_h}, 3'b111);
        check_val("rst_f0_audio", {audio_of(0, 0), audio_of(0, 1)}, 0);
        capture_frame();
        check_val("rst_f1_discarded", {ur_h, audio_of(0, 0)}, {1'b1, 24'h0});
        check_val("rst_f1_preamble_m", pre_of(0, 0), 8'b11100010);

        finish_now();
    end

endmodule
